rr_sel_arbiter4: RTL and testbench
==================================

# rr_sel_arbiter4

Round-robin arbiter that owns the 2-bit select of the team's 4:1 single-bit mux (`mux4_1`). Four requesters compete for the mux; the arbiter grants one at a time, drives `sel` to the granted input index, and holds it stable for the whole grant. A grant ends on completion, request withdrawal or hold timeout. The block sits directly upstream of `mux4_1` and feeds its `sel` input.

## Interface
- `MAX_HOLD`, default 8: maximum number of cycles a grant may stay valid. Legal range 0..255. A value of 0 disables the timeout.

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, 4: request vector; bit i requests mux input Ii.
- `done`, input, 1: the current grant holder finished; sampled only while a grant is valid.
- `sel`, output, 2: mux select, equal to the index of the granted requester.
- `gnt`, output, 4: one-hot grant; all zero when no grant is valid.
- `gnt_valid`, output, 1: a grant is active and `sel` is guaranteed stable.
- `timeout`, output, 1: one-cycle pulse when a grant is force-released.

## Operation
- State machine with two states, IDLE and GRANT.
- Internal registers:
  - `last`, 2 bits: index of the most recent grant.
  - `hold_cnt`, 8 bits.
- Reset (asynchronous, immediate) sets the following values:
  - state = IDLE
  - `sel` = 0, `gnt` = 0, `gnt_valid` = 0, `timeout` = 0
  - `last` = 3, so channel 0 has top priority first
  - `hold_cnt` = 0
- IDLE:
  - If `req` != 0 at the edge, pick the first set bit searching circularly from `last`+1.
  - Register `sel` = index, `gnt` = onehot(index), `gnt_valid` = 1, `last` = index, `hold_cnt` = 1, and move to GRANT.
  - If `req` == 0, stay in IDLE with all outputs unchanged.
- GRANT has three release conditions, evaluated at each edge:
  - `done` = 1 → release.
  - `req[sel]` = 0 (requester withdrew) → release, with no timeout.
  - `MAX_HOLD` != 0 and `hold_cnt` == `MAX_HOLD` → forced release, and `timeout` = 1 for the next cycle.
  - Otherwise `hold_cnt` increments and `sel`/`gnt` hold.
- Release: `gnt` = 0, `gnt_valid` = 0, return to IDLE. `sel` keeps its last value, so the mux output does not glitch.
- Priority when several release conditions coincide: `done` or withdrawal wins over timeout, and `timeout` is not pulsed.
- Fairness:
  - The pointer advances past a requester even when it was force-released.
  - Every continuously requesting channel is granted within 4 grants.
- `done` is ignored in IDLE.
- `req` changes in GRANT other than the holder's own bit have no effect.

## Timing
- Request-to-grant latency is 1 edge. `req` sampled at edge k gives `gnt_valid`=1 after edge k.
- Release latency is 1 edge. `done` sampled high at edge k gives `gnt_valid`=0 after edge k.
- At least one IDLE cycle (`gnt_valid`=0) always separates two grants, including back-to-back grants to the same channel.
- With `MAX_HOLD`=M, `done` never asserted and `req` held: `gnt_valid` is high for exactly M cycles, then `timeout` is high for 1 cycle while `gnt_valid`=0.
- `sel` changes only on the edge that raises `gnt_valid`. It is constant while `gnt_valid`=1 and during the idle gap.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-grant clears all outputs immediately, without waiting for a clock edge. After reset release, the first grant goes to the lowest-index requester.

## Test plan
- Reset:
  - Stimulus: hold `rst_n`=0 with `req`=1111.
  - Required: `sel`=00, `gnt`=0000, `gnt_valid`=0, `timeout`=0.
  - After release, the first grant is `gnt`=0001.
- Single requester:
  - Stimulus: `req`=0100 held, `done` pulsed on the 3rd grant cycle.
  - Required: `sel`=10 and `gnt`=0100 for 3 cycles, then `gnt_valid`=0 and `sel` stays 10.
- Round robin:
  - Stimulus: `req`=1111, `done` pulsed on the first cycle of each grant.
  - Required: grant order 0,1,2,3,0, with exactly one `gnt_valid`=0 cycle between grants.
- Timeout:
  - Stimulus: `MAX_HOLD`=8, `req`=0001 held, no `done`.
  - Required: `gnt_valid` high for exactly 8 cycles, `timeout` pulses once, then one idle cycle, then channel 0 is re-granted.
- Coincident events:
  - Stimulus: `done`=1 on the cycle `hold_cnt` reaches `MAX_HOLD`.
  - Required: release with `timeout`=0.
  - Stimulus: the holder drops its `req` bit mid-grant.
  - Required: release on the next edge with no timeout.
- Reset mid-grant:
  - Stimulus: assert `rst_n`=0 asynchronously while channel 2 is granted.
  - Required: outputs clear before the next clock edge.
  - After release with `req`=1111, the first grant is channel 0.

Source files
------------

// File: rtl/rr_sel_arbiter4.sv
// rr_sel_arbiter4: round-robin arbiter that owns the 2-bit select of mux4_1.
// One requester holds the mux at a time. A grant ends on done, on the holder
// withdrawing its request, or when it has been valid for MAX_HOLD cycles.
// All outputs are registered, and sel only moves on the edge that grants.
module rr_sel_arbiter4 #(
  parameter int MAX_HOLD = 8  // 0 disables the hold timeout, legal 0..255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  logic [0:0] state;
  logic [1:0] last;      // index of the most recent grant
  logic [7:0] hold_cnt;  // cycles the current grant has been valid
  logic [1:0] pick_idx;
  logic       holder_release;
  logic       hold_expired;

  // Next winner: first set request bit searching circularly from last+1.
  always_comb begin
    // NOTE: default first so every path assigns pick_idx and no latch is inferred.
    pick_idx = last;
    // Walk the offsets far-to-near so the nearest requester is written last and wins.
    for (int k = 4; k >= 1; k--) begin
      if (req[last + 2'(k)]) begin
        pick_idx = last + 2'(k);
      end
    end
  end

  // Voluntary release (done or withdrawal) takes precedence over the timeout.
  assign holder_release = done | ~req[sel];
  assign hold_expired   = (HOLD_LIMIT != 8'd0) && (hold_cnt == HOLD_LIMIT);

  // Grant state machine and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sel       <= 2'd0;
      gnt       <= 4'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      last      <= 2'd3;  // channel 0 gets first priority out of reset
      hold_cnt  <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      case (state)
        ST_IDLE: begin
          timeout <= 1'b0;
          if (req != 4'd0) begin
            sel       <= pick_idx;
            gnt       <= 4'b0001 << pick_idx;
            gnt_valid <= 1'b1;
            last      <= pick_idx;
            hold_cnt  <= 8'd1;
            state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (holder_release) begin
            gnt       <= 4'd0;
            gnt_valid <= 1'b0;
            state     <= ST_IDLE;
          end else if (hold_expired) begin
            gnt       <= 4'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          gnt       <= 4'd0;
          gnt_valid <= 1'b0;
          timeout   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_sel_arbiter4.sv
// Self-checking bench for rr_sel_arbiter4: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_rr_sel_arbiter4;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  int checks;
  int errors;

  // Reference model: owner index (-1 = none), rotating pointer, hold counter.
  int m_owner;
  int m_last;
  int m_cnt;
  int m_sel;
  bit m_timeout;

  rr_sel_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .sel      (sel),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_last    = 3;
    m_cnt     = 0;
    m_sel     = 0;
    m_timeout = 1'b0;
  endtask

  // One clock edge of the arbitration rules, using the sampled inputs.
  task automatic model_edge(input logic [3:0] r, input logic d);
    if (m_owner < 0) begin
      m_timeout = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        int idx;
        idx = (m_last + k) % 4;
        if (m_owner < 0 && r[idx]) begin
          m_owner = idx;
          m_sel   = idx;
          m_last  = idx;
          m_cnt   = 1;
        end
      end
    end else if (d || !r[m_owner]) begin
      m_owner = -1;
    end else if (MAX_HOLD != 0 && m_cnt == MAX_HOLD) begin
      m_owner   = -1;
      m_timeout = 1'b1;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic compare(input string tag);
    check({tag, ".sel"},       32'(sel),       32'(m_sel));
    check({tag, ".gnt"},       32'(gnt),       (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    check({tag, ".gnt_valid"}, 32'(gnt_valid), (m_owner < 0) ? 32'd0 : 32'd1);
    check({tag, ".timeout"},   32'(timeout),   32'(m_timeout));
  endtask

  // Drive inputs, take one edge, sample 1 time unit later.
  task automatic step(input logic [3:0] r, input logic d, input string tag);
    req  = r;
    done = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    compare(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    model_reset();

    // Reset held with all requests active.
    rst_n = 1'b0;
    req   = 4'b1111;
    done  = 1'b0;
    #12;
    check("reset.sel",       32'(sel),       32'd0);
    check("reset.gnt",       32'(gnt),       32'd0);
    check("reset.gnt_valid", 32'(gnt_valid), 32'd0);
    check("reset.timeout",   32'(timeout),   32'd0);
    rst_n = 1'b1;
    step(4'b1111, 1'b0, "reset_first");
    check("reset_first_gnt", 32'(gnt), 32'b0001);
    step(4'b1111, 1'b1, "reset_first_rel");

    // Single requester, done on the 3rd grant cycle.
    step(4'b0100, 1'b0, "single_grant");
    check("single_sel", 32'(sel), 32'b10);
    step(4'b0100, 1'b0, "single_c2");
    step(4'b0100, 1'b0, "single_c3");
    check("single_gnt_c3", 32'(gnt), 32'b0100);
    step(4'b0100, 1'b1, "single_rel");
    check("single_rel_valid", 32'(gnt_valid), 32'd0);
    check("single_rel_sel", 32'(sel), 32'b10);
    step(4'b0000, 1'b0, "single_idle");

    // Round robin from a fresh reset: order 0,1,2,3,0 with one idle cycle between.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b0, $sformatf("rr_grant%0d", i));
      check($sformatf("rr_order%0d", i), 32'(gnt), 32'd1 << (i % 4));
      step(4'b1111, 1'b1, $sformatf("rr_rel%0d", i));
      check($sformatf("rr_gap%0d", i), 32'(gnt_valid), 32'd0);
    end

    // Timeout: channel 0 held, no done.
    step(4'b0001, 1'b0, "to_grant");
    n = 0;
    while (gnt_valid && n < 20) begin
      n++;
      step(4'b0001, 1'b0, "to_hold");
    end
    check("to_valid_cycles", 32'(n), 32'(MAX_HOLD));
    check("to_pulse", 32'(timeout), 32'd1);
    step(4'b0001, 1'b0, "to_regrant");
    check("to_regrant_gnt", 32'(gnt), 32'b0001);
    check("to_pulse_end", 32'(timeout), 32'd0);

    // done coincides with the hold limit: plain release, no timeout.
    for (int i = 2; i <= MAX_HOLD; i++) step(4'b0001, 1'b0, "co_hold");
    step(4'b0001, 1'b1, "co_done");
    check("co_done_timeout", 32'(timeout), 32'd0);
    check("co_done_valid", 32'(gnt_valid), 32'd0);

    // Holder withdraws mid-grant.
    step(4'b0010, 1'b0, "wd_grant");
    step(4'b0010, 1'b0, "wd_hold");
    step(4'b0000, 1'b0, "wd_drop");
    check("wd_timeout", 32'(timeout), 32'd0);
    check("wd_valid", 32'(gnt_valid), 32'd0);

    // Asynchronous reset while channel 2 holds the grant.
    step(4'b0100, 1'b0, "mr_grant");
    check("mr_gnt", 32'(gnt), 32'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr.sel",       32'(sel),       32'd0);
    check("mr.gnt",       32'(gnt),       32'd0);
    check("mr.gnt_valid", 32'(gnt_valid), 32'd0);
    check("mr.timeout",   32'(timeout),   32'd0);
    model_reset();
    #3;
    rst_n = 1'b1;
    step(4'b1111, 1'b0, "mr_first");
    check("mr_first_gnt", 32'(gnt), 32'b0001);

    // Randomized traffic: requests mostly held so timeouts occur, done is rare.
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] r;
      logic       d;
      for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 7) != 0);
      d = ($urandom_range(0, 15) == 0);
      step(r, d, $sformatf("rand%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
